aq_hpcp_ovf_ctrl: RTL and testbench

- Consumer side of the HPM counter overflow interface.
- Collects the one-cycle overflow pulses from every performance counter into a sticky overflow status register, which CP0 reads and writes with CSR write/set/clear semantics.
- Drives per-counter freeze requests back to the counters.
- Runs a request/acknowledge FSM that raises the PMU overflow interrupt to CP0 and reports the lowest pending counter index.

---
 rtl/aq_hpcp_ovf_ctrl.sv | 130 +++++++++++++
 tb/tb_aq_hpcp_ovf_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/aq_hpcp_ovf_ctrl.sv
// Purpose: sticky HPM overflow status with CSR write/set/clear, per-counter freeze, PMU interrupt req/ack FSM.
// Latency: overflow pulse -> status bit +1 cycle; -> int_vld and ovf_idx +2 cycles; freeze follows status combinationally.
// Backpressure: none; overflow pulses are never dropped, and an interrupt is held until CP0 acks or software clears it.
module aq_hpcp_ovf_ctrl #(
    parameter int CNT_NUM = 32,
    parameter int IDX_W   = 5
) (
    input  logic               forever_cpuclk,
    input  logic               cpurst,
    input  logic [CNT_NUM-1:0] hpcp_cnt_of,
    input  logic [CNT_NUM-1:0] hpcp_ovf_inten,
    input  logic [CNT_NUM-1:0] hpcp_ovf_frzen,
    input  logic               cp0_hpcp_ovf_wen,
    input  logic [1:0]         cp0_hpcp_ovf_op,
    input  logic [CNT_NUM-1:0] cp0_hpcp_ovf_wdata,
    input  logic               cp0_hpcp_int_ack,
    output logic [CNT_NUM-1:0] hpcp_ovf_status,
    output logic [CNT_NUM-1:0] hpcp_cnt_freeze,
    output logic               hpcp_cp0_int_vld,
    output logic [IDX_W-1:0]   hpcp_cp0_ovf_idx
);

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_SET   = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_ACKED = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_NUM-1:0] status_q, status_d;
    logic [CNT_NUM-1:0] ack_mask_q, ack_mask_d;
    logic [IDX_W-1:0]   ovf_idx_q, ovf_idx_d;
    logic               int_vld_q, int_vld_d;

    logic [CNT_NUM-1:0] csr_result;
    logic [CNT_NUM-1:0] enabled;
    logic [CNT_NUM-1:0] new_src;
    logic               pending;

    // Index of the lowest set bit; zero when nothing is set.
    function automatic logic [IDX_W-1:0] lowest_idx(input logic [CNT_NUM-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = CNT_NUM - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction

    // Software view of the status register after this cycle's CSR access.
    always_comb begin
        csr_result = status_q;
        if (cp0_hpcp_ovf_wen) begin
            case (cp0_hpcp_ovf_op)
                OP_WRITE: csr_result = cp0_hpcp_ovf_wdata;
                OP_SET:   csr_result = status_q | cp0_hpcp_ovf_wdata;
                OP_CLEAR: csr_result = status_q & ~cp0_hpcp_ovf_wdata;
                default:  csr_result = status_q;
            endcase
        end
    end

    // Hardware pulses are OR-ed last so they always beat a same-cycle clear.
    assign status_d = csr_result | hpcp_cnt_of;
    assign enabled  = status_q & hpcp_ovf_inten;
    assign new_src  = enabled & ~ack_mask_q;
    assign pending  = |enabled;

    // Interrupt handshake: request, wait for ack, re-request only for unacknowledged sources.
    always_comb begin
        state_d    = state_q;
        ack_mask_d = ack_mask_q;
        ovf_idx_d  = ovf_idx_q;
        case (state_q)
            ST_IDLE: begin
                if (pending) begin
                    state_d   = ST_REQ;
                    ovf_idx_d = lowest_idx(enabled);
                end
            end
            ST_REQ: begin
                if (cp0_hpcp_int_ack) begin
                    state_d    = ST_ACKED;
                    ack_mask_d = enabled;
                end else if (!pending) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACKED: begin
                if (!pending) begin
                    state_d = ST_IDLE;
                end else if (|new_src) begin
                    state_d   = ST_REQ;
                    ovf_idx_d = lowest_idx(new_src);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        int_vld_d = (state_d == ST_REQ);
    end

    // State and output registers; reset overrides every same-cycle input.
    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            state_q    <= ST_IDLE;
            status_q   <= '0;
            ack_mask_q <= '0;
            ovf_idx_q  <= '0;
            int_vld_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            status_q   <= status_d;
            ack_mask_q <= ack_mask_d;
            ovf_idx_q  <= ovf_idx_d;
            int_vld_q  <= int_vld_d;
        end
    end

    assign hpcp_ovf_status  = status_q;
    assign hpcp_cnt_freeze  = status_q & hpcp_ovf_frzen;
    assign hpcp_cp0_int_vld = int_vld_q;
    assign hpcp_cp0_ovf_idx = ovf_idx_q;

endmodule

// File: tb/tb_aq_hpcp_ovf_ctrl.sv
// Purpose: self-checking bench for aq_hpcp_ovf_ctrl (directed vector table, latency probe, randomized vs. reference model).
// Latency: inputs driven on falling edge, outputs sampled 1 time unit after the rising edge.
// Backpressure: not applicable.
module tb_aq_hpcp_ovf_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] cnt_of, inten, frzen, wdata;
    logic        wen, ack;
    logic [1:0]  op;
    logic [31:0] status, freeze;
    logic        int_vld;
    logic [4:0]  ovf_idx;

    int n_checks = 0;
    int n_errors = 0;

    aq_hpcp_ovf_ctrl #(.CNT_NUM(32), .IDX_W(5)) dut (
        .forever_cpuclk     (clk),
        .cpurst             (rst),
        .hpcp_cnt_of        (cnt_of),
        .hpcp_ovf_inten     (inten),
        .hpcp_ovf_frzen     (frzen),
        .cp0_hpcp_ovf_wen   (wen),
        .cp0_hpcp_ovf_op    (op),
        .cp0_hpcp_ovf_wdata (wdata),
        .cp0_hpcp_int_ack   (ack),
        .hpcp_ovf_status    (status),
        .hpcp_cnt_freeze    (freeze),
        .hpcp_cp0_int_vld   (int_vld),
        .hpcp_cp0_ovf_idx   (ovf_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [31:0] of;
        logic [31:0] inten;
        logic [31:0] frzen;
        logic        wen;
        logic [1:0]  op;
        logic [31:0] wdata;
        logic        ack;
        logic [31:0] exp_status;
        logic [31:0] exp_freeze;
        logic        exp_vld;
        logic [4:0]  exp_idx;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic [31:0] o, input logic [31:0] ie,
                                input logic [31:0] fz, input logic w, input logic [1:0] p,
                                input logic [31:0] wd, input logic a, input logic [31:0] es,
                                input logic [31:0] ef, input logic ev, input logic [4:0] ei);
        vec_t v;
        v.rst = r; v.of = o; v.inten = ie; v.frzen = fz; v.wen = w; v.op = p; v.wdata = wd;
        v.ack = a; v.exp_status = es; v.exp_freeze = ef; v.exp_vld = ev; v.exp_idx = ei;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs on the falling edge, let the rising edge take them, sample after it.
    task automatic drive(input logic r, input logic [31:0] o, input logic [31:0] ie,
                         input logic [31:0] fz, input logic w, input logic [1:0] p,
                         input logic [31:0] wd, input logic a);
        @(negedge clk);
        rst = r; cnt_of = o; inten = ie; frzen = fz; wen = w; op = p; wdata = wd; ack = a;
        @(posedge clk);
        #1;
    endtask

    // Reference model: sticky event set plus an interrupt handshake over "sources already acknowledged".
    typedef enum int { M_IDLE, M_WAIT_ACK, M_SERVICED } mphase_t;
    logic [31:0] m_status, m_acked;
    mphase_t     m_phase;
    int          m_idx;

    function automatic int first_one(input logic [31:0] v);
        for (int i = 0; i < 32; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic model_step(input logic r, input logic [31:0] o, input logic [31:0] ie,
                              input logic w, input logic [1:0] p, input logic [31:0] wd,
                              input logic a);
        logic [31:0] sw_view, live;
        if (r) begin
            m_status = 0; m_acked = 0; m_phase = M_IDLE; m_idx = 0;
            return;
        end
        live = m_status & ie;
        if (m_phase == M_IDLE) begin
            if (live != 0) begin m_phase = M_WAIT_ACK; m_idx = first_one(live); end
        end else if (m_phase == M_WAIT_ACK) begin
            if (a) begin m_phase = M_SERVICED; m_acked = live; end
            else if (live == 0) m_phase = M_IDLE;
        end else begin
            if (live == 0) m_phase = M_IDLE;
            else if ((live & ~m_acked) != 0) begin
                m_phase = M_WAIT_ACK; m_idx = first_one(live & ~m_acked);
            end
        end
        sw_view = m_status;
        if (w && p == 2'd0) sw_view = wd;
        else if (w && p == 2'd1) sw_view = m_status | wd;
        else if (w && p == 2'd2) sw_view = m_status & ~wd;
        m_status = sw_view | o;
    endtask

    initial begin
        int lat;
        logic [31:0] r_of, r_wd, r_ie, r_fz;
        logic        r_rst, r_wen, r_ack;
        logic [1:0]  r_op;

        rst = 1'b1; cnt_of = 0; inten = 0; frzen = 0; wen = 0; op = 2'd3; wdata = 0; ack = 0;

        // Directed sequence: each row is applied for one edge, then the outputs after that edge are checked.
        vecs.push_back(mk(1, 32'h0,        32'hFF,       32'h0, 0, 2'd0, 32'h0,    0, 32'h0,        32'h0, 0, 5'd0));
        vecs.push_back(mk(0, 32'h20,       32'hFF,       32'h0, 0, 2'd0, 32'h0,    0, 32'h20,       32'h0, 0, 5'd0));
        vecs.push_back(mk(0, 32'h0,        32'hFF,       32'h0, 0, 2'd0, 32'h0,    0, 32'h20,       32'h0, 1, 5'd5));
        vecs.push_back(mk(0, 32'h0,        32'hFF,       32'h0, 0, 2'd0, 32'h0,    1, 32'h20,       32'h0, 0, 5'd5));
        vecs.push_back(mk(0, 32'h80,       32'hFF,       32'h0, 0, 2'd0, 32'h0,    0, 32'hA0,       32'h0, 0, 5'd5));
        vecs.push_back(mk(0, 32'h0,        32'hFF,       32'h0, 0, 2'd0, 32'h0,    0, 32'hA0,       32'h0, 1, 5'd7));
        vecs.push_back(mk(0, 32'h0,        32'hFF,       32'h0, 0, 2'd0, 32'h0,    1, 32'hA0,       32'h0, 0, 5'd7));
        vecs.push_back(mk(0, 32'h0,        32'hFF,       32'h0, 1, 2'd0, 32'h0,    0, 32'h0,        32'h0, 0, 5'd7));
        vecs.push_back(mk(0, 32'h0,        32'hFF,       32'h0, 0, 2'd0, 32'h0,    0, 32'h0,        32'h0, 0, 5'd7));
        vecs.push_back(mk(0, 32'h0,        32'hFF,       32'h0, 0, 2'd0, 32'h0,    0, 32'h0,        32'h0, 0, 5'd7));
        vecs.push_back(mk(0, 32'h8,        32'hFF,       32'h0, 0, 2'd0, 32'h0,    0, 32'h8,        32'h0, 0, 5'd7));
        vecs.push_back(mk(0, 32'h8,        32'hFF,       32'h0, 1, 2'd2, 32'h8,    0, 32'h8,        32'h0, 1, 5'd3));
        vecs.push_back(mk(0, 32'h0,        32'hFF,       32'h0, 1, 2'd2, 32'h8,    0, 32'h0,        32'h0, 1, 5'd3));
        vecs.push_back(mk(0, 32'h0,        32'hFF,       32'h0, 0, 2'd0, 32'h0,    0, 32'h0,        32'h0, 0, 5'd3));
        vecs.push_back(mk(0, 32'h4,        32'hFF,       32'h4, 0, 2'd0, 32'h0,    0, 32'h4,        32'h4, 0, 5'd3));
        vecs.push_back(mk(0, 32'h0,        32'hFF,       32'h4, 0, 2'd0, 32'h0,    0, 32'h4,        32'h4, 1, 5'd2));
        vecs.push_back(mk(0, 32'h0,        32'hFF,       32'h4, 1, 2'd2, 32'h4,    0, 32'h0,        32'h0, 1, 5'd2));
        vecs.push_back(mk(0, 32'h0,        32'hFF,       32'h4, 0, 2'd0, 32'h0,    0, 32'h0,        32'h0, 0, 5'd2));
        vecs.push_back(mk(0, 32'h0,        32'hFF,       32'h0, 1, 2'd1, 32'h300,  0, 32'h300,      32'h0, 0, 5'd2));
        vecs.push_back(mk(0, 32'h0,        32'h200,      32'h0, 0, 2'd0, 32'h0,    0, 32'h300,      32'h0, 1, 5'd9));
        vecs.push_back(mk(0, 32'h0,        32'h0,        32'h0, 0, 2'd0, 32'h0,    0, 32'h300,      32'h0, 0, 5'd9));
        vecs.push_back(mk(0, 32'h0,        32'h0,        32'h0, 1, 2'd3, 32'hFFFF, 0, 32'h300,      32'h0, 0, 5'd9));
        vecs.push_back(mk(0, 32'h0,        32'h0,        32'h0, 0, 2'd0, 32'h0,    1, 32'h300,      32'h0, 0, 5'd9));
        vecs.push_back(mk(0, 32'h0,        32'hFFFFFF,   32'h0, 0, 2'd0, 32'h0,    0, 32'h300,      32'h0, 1, 5'd8));
        vecs.push_back(mk(1, 32'h1,        32'hFFFFFF,   32'hFFFFFFFF, 0, 2'd0, 32'h0, 0, 32'h0,    32'h0, 0, 5'd0));
        vecs.push_back(mk(0, 32'h0,        32'hFFFFFFFF, 32'h0, 0, 2'd0, 32'h0,    0, 32'h0,        32'h0, 0, 5'd0));
        vecs.push_back(mk(0, 32'h80000010, 32'hFFFFFFFF, 32'h0, 0, 2'd0, 32'h0,    0, 32'h80000010, 32'h0, 0, 5'd0));
        vecs.push_back(mk(0, 32'h0,        32'hFFFFFFFF, 32'h0, 0, 2'd0, 32'h0,    0, 32'h80000010, 32'h0, 1, 5'd4));
        vecs.push_back(mk(0, 32'h0,        32'h80000000, 32'h0, 0, 2'd0, 32'h0,    0, 32'h80000010, 32'h0, 1, 5'd4));
        vecs.push_back(mk(0, 32'h0,        32'h80000000, 32'h0, 0, 2'd0, 32'h0,    1, 32'h80000010, 32'h0, 0, 5'd4));
        vecs.push_back(mk(0, 32'h0,        32'hFFFFFFFF, 32'h0, 0, 2'd0, 32'h0,    0, 32'h80000010, 32'h0, 1, 5'd4));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].of, vecs[i].inten, vecs[i].frzen,
                  vecs[i].wen, vecs[i].op, vecs[i].wdata, vecs[i].ack);
            check($sformatf("vec%0d_status", i), status, vecs[i].exp_status);
            check($sformatf("vec%0d_freeze", i), freeze, vecs[i].exp_freeze);
            check($sformatf("vec%0d_int_vld", i), {31'b0, int_vld}, {31'b0, vecs[i].exp_vld});
            check($sformatf("vec%0d_ovf_idx", i), {27'b0, ovf_idx}, {27'b0, vecs[i].exp_idx});
        end

        // Latency probe: pulse on counter 13 must raise int_vld exactly two edges later.
        drive(1, 0, 32'hFFFFFFFF, 0, 0, 2'd3, 0, 0);
        drive(0, 32'h2000, 32'hFFFFFFFF, 0, 0, 2'd3, 0, 0);
        lat = 1;
        while (!int_vld && lat < 6) begin
            drive(0, 0, 32'hFFFFFFFF, 0, 0, 2'd3, 0, 0);
            lat++;
        end
        check("latency_pulse_to_int_vld", lat, 2);
        check("latency_ovf_idx", {27'b0, ovf_idx}, 32'd13);

        // Randomized phase against the reference model.
        drive(1, 0, 0, 0, 0, 2'd3, 0, 0);
        model_step(1, 0, 0, 0, 2'd3, 0, 0);
        r_ie = 32'hFFFF;
        r_fz = 32'h0;
        for (int c = 0; c < 3000; c++) begin
            r_rst = ($urandom_range(0, 199) == 0);
            r_of  = 0;
            if ($urandom_range(0, 3) == 0) r_of[$urandom_range(0, 31)] = 1'b1;
            if ($urandom_range(0, 15) == 0) r_of[$urandom_range(0, 31)] = 1'b1;
            if ($urandom_range(0, 31) == 0) r_ie = $urandom;
            if ($urandom_range(0, 31) == 0) r_fz = $urandom;
            r_wen = ($urandom_range(0, 5) == 0);
            r_op  = 2'($urandom_range(0, 3));
            r_wd  = ($urandom_range(0, 1) == 0) ? $urandom : (32'h1 << $urandom_range(0, 31));
            r_ack = ($urandom_range(0, 3) == 0);
            drive(r_rst, r_of, r_ie, r_fz, r_wen, r_op, r_wd, r_ack);
            model_step(r_rst, r_of, r_ie, r_wen, r_op, r_wd, r_ack);
            check("rnd_status", status, m_status);
            check("rnd_freeze", freeze, m_status & r_fz);
            check("rnd_int_vld", {31'b0, int_vld}, {31'b0, (m_phase == M_WAIT_ACK)});
            check("rnd_ovf_idx", {27'b0, ovf_idx}, 32'(m_idx));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
